hese_term_scheduler: RTL and testbench

Sequences LANES instances of the bit-serial HESE encoder for term quantization. It accepts one parallel word per lane and serializes each word MSB-first, with zero guard bits, into its lane's encoder. It drives each encoder's power_on, collects the returned signed-digit stream, and keeps only the first (most significant) `budget` nonzero terms per lane. It sits between the weight/activation buffer and the term-serial MAC array.

---
 rtl/hese_pkg.sv | 18 +
 rtl/hese_lane_budget.sv | 102 ++++++++++
 rtl/hese_term_scheduler.sv | 161 ++++++++++++++++
 tb/tb_hese_term_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hese_pkg.sv
// Shared definitions for the HESE term scheduler.
// Holds the default geometry (lanes, word width, counter widths) and the
// scheduler FSM state type.
package hese_pkg;

    localparam int unsigned DEF_LANES = 4;
    localparam int unsigned DEF_W     = 8;
    localparam int unsigned DEF_BUD_W = $clog2(DEF_W + 2);
    localparam int unsigned DEF_CNT_W = $clog2(DEF_W + 3);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/hese_lane_budget.sv
// One encoder lane of the HESE term scheduler.
// Serializes the latched word MSB-first with a zero guard bit on each side,
// drives the encoder power_on from a falling-edge flop, and keeps only the
// first `budget` nonzero digits returned by the encoder.
//
// Ports:
//   clk, reset       system clock, async active-high reset
//   accept           load word/budget and clear per-op state
//   word, budget     lane word and term budget to latch on accept
//   shifting         scheduler is in SHIFT (advance the serializer)
//   power_window     scheduler is in SHIFT or DRAIN
//   term_valid       current encoder digit is a real slot
//   enc_output/sign  digit magnitude/sign from the encoder
//   enc_input        serial bit to the encoder
//   enc_power_on     encoder clock enable (changes on falling edge)
//   term_mag/sign    kept digit
//   kept_cnt         digits kept this op
//   dropped          a nonzero digit was masked this op
module hese_lane_budget
    import hese_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned BUD_W = DEF_BUD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic [W-1:0]     word,
    input  logic [BUD_W-1:0] budget,
    input  logic             shifting,
    input  logic             power_window,
    input  logic             term_valid,
    input  logic             enc_output,
    input  logic             enc_sign,
    output logic             enc_input,
    output logic             enc_power_on,
    output logic             term_mag,
    output logic             term_sign,
    output logic [BUD_W-1:0] kept_cnt,
    output logic             dropped
);

    // Stream s_0..s_{W+1} = 0, b_{W-1}..b_0, 0; the MSB is the current bit.
    logic [W+1:0]     sreg_q;
    logic             nz_q;
    logic [BUD_W-1:0] budget_q;
    logic [BUD_W-1:0] cnt_q;
    logic             dropped_q;
    logic             power_q;

    logic digit_nz;
    logic under_budget;
    logic keep;

    // A zero word never powers its encoder, so its stale output is ignored.
    assign digit_nz     = term_valid & nz_q & enc_output;
    assign under_budget = cnt_q < budget_q;
    assign keep         = digit_nz & under_budget;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q    <= '0;
            nz_q      <= 1'b0;
            budget_q  <= '0;
            cnt_q     <= '0;
            dropped_q <= 1'b0;
        end else if (accept) begin
            sreg_q    <= {1'b0, word, 1'b0};
            nz_q      <= |word;
            budget_q  <= budget;
            cnt_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            if (shifting) begin
                sreg_q <= {sreg_q[W:0], 1'b0};
            end
            if (keep) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (digit_nz && !under_budget) begin
                dropped_q <= 1'b1;
            end
        end
    end

    // Updated while clk is low so clk & power_on never glitches.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            power_q <= 1'b0;
        end else begin
            power_q <= power_window & nz_q;
        end
    end

    assign enc_input    = shifting & sreg_q[W+1];
    assign enc_power_on = power_q;
    assign term_mag     = keep;
    assign term_sign    = keep & enc_sign;
    assign kept_cnt     = cnt_q;
    assign dropped      = dropped_q;

endmodule

// File: rtl/hese_term_scheduler.sv
// HESE term scheduler: drives LANES bit-serial HESE encoders in lock-step
// and emits their budget-limited signed-digit terms, MSB weight first.
//
// Ports:
//   clk, reset          system clock, async active-high reset
//   in_valid/in_ready   word-set handshake (ready only in IDLE)
//   in_data, in_budget  lane words and per-lane term budget
//   enc_input           serial bits to the encoders
//   enc_power_on        encoder clock enables
//   enc_output/enc_sign digit stream from the encoders
//   term_valid          digit slot valid for all lanes
//   term_mag/term_sign  kept digit per lane
//   term_weight         exponent k of the current slot
//   term_last           asserted with the k=0 slot
//   done                one-cycle pulse after the last slot
//   kept_cnt, dropped   per-lane results, held until the next accept
//
// Op timeline (cycle 0 = first SHIFT cycle): SHIFT 0..W+1, DRAIN W+2,
// DONE W+3. Encoder digit of weight k is presented in cycle W+2-k.
module hese_term_scheduler
    import hese_pkg::*;
#(
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned BUD_W = $clog2(W + 2),
    parameter int unsigned CNT_W = $clog2(W + 3)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*W-1:0]     in_data,
    input  logic [BUD_W-1:0]       in_budget,
    output logic [LANES-1:0]       enc_input,
    output logic [LANES-1:0]       enc_power_on,
    input  logic [LANES-1:0]       enc_output,
    input  logic [LANES-1:0]       enc_sign,
    output logic                   term_valid,
    output logic [LANES-1:0]       term_mag,
    output logic [LANES-1:0]       term_sign,
    output logic [CNT_W-1:0]       term_weight,
    output logic                   term_last,
    output logic                   done,
    output logic [LANES*BUD_W-1:0] kept_cnt,
    output logic [LANES-1:0]       dropped
);

    localparam logic [CNT_W-1:0] SeqShiftLast = CNT_W'(W + 1);
    localparam logic [CNT_W-1:0] SeqFirstTerm = CNT_W'(2);
    localparam logic [CNT_W-1:0] SeqLastTerm  = CNT_W'(W + 2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] seq_q, seq_d;

    logic             in_ready_q, in_ready_d;
    logic             term_valid_q, term_valid_d;
    logic [CNT_W-1:0] term_weight_q, term_weight_d;
    logic             term_last_q, term_last_d;
    logic             done_q, done_d;

    logic accept;
    logic shifting;
    logic power_window;

    assign accept       = in_valid & in_ready_q;
    assign shifting     = (state_q == StShift);
    assign power_window = (state_q == StShift) || (state_q == StDrain);

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                    seq_d   = '0;
                end
            end
            StShift: begin
                seq_d = seq_q + 1'b1;
                if (seq_q == SeqShiftLast) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                seq_d   = seq_q + 1'b1;
                state_d = StDone;
            end
            StDone: begin
                seq_d   = '0;
                state_d = StIdle;
            end
            default: begin
                seq_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    // The slot at seq 1 carries stale encoder state and is never valid.
    always_comb begin
        term_valid_d  = ((state_d == StShift) || (state_d == StDrain)) &&
                        (seq_d >= SeqFirstTerm) && (seq_d <= SeqLastTerm);
        term_weight_d = term_valid_d ? (SeqLastTerm - seq_d) : '0;
        term_last_d   = term_valid_d && (seq_d == SeqLastTerm);
        done_d        = (state_d == StDone);
        in_ready_d    = (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            seq_q         <= '0;
            in_ready_q    <= 1'b1;
            term_valid_q  <= 1'b0;
            term_weight_q <= '0;
            term_last_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            seq_q         <= seq_d;
            in_ready_q    <= in_ready_d;
            term_valid_q  <= term_valid_d;
            term_weight_q <= term_weight_d;
            term_last_q   <= term_last_d;
            done_q        <= done_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        hese_lane_budget #(
            .W     (W),
            .BUD_W (BUD_W)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .accept       (accept),
            .word         (in_data[i*W +: W]),
            .budget       (in_budget),
            .shifting     (shifting),
            .power_window (power_window),
            .term_valid   (term_valid_q),
            .enc_output   (enc_output[i]),
            .enc_sign     (enc_sign[i]),
            .enc_input    (enc_input[i]),
            .enc_power_on (enc_power_on[i]),
            .term_mag     (term_mag[i]),
            .term_sign    (term_sign[i]),
            .kept_cnt     (kept_cnt[i*BUD_W +: BUD_W]),
            .dropped      (dropped[i])
        );
    end

    assign in_ready    = in_ready_q;
    assign term_valid  = term_valid_q;
    assign term_weight = term_weight_q;
    assign term_last   = term_last_q;
    assign done        = done_q;

endmodule

// File: tb/tb_hese_term_scheduler.sv
// Bench for hese_term_scheduler: models the HESE encoders, predicts the
// Booth-style digit stream per word, and scoreboards slots and results.
module tb_hese_term_scheduler;

    localparam int LANES = 4;
    localparam int W     = 8;
    localparam int BUD_W = 4;
    localparam int CNT_W = 4;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*W-1:0]     in_data;
    logic [BUD_W-1:0]       in_budget;
    logic [LANES-1:0]       enc_input;
    logic [LANES-1:0]       enc_power_on;
    logic [LANES-1:0]       enc_output;
    logic [LANES-1:0]       enc_sign;
    logic                   term_valid;
    logic [LANES-1:0]       term_mag;
    logic [LANES-1:0]       term_sign;
    logic [CNT_W-1:0]       term_weight;
    logic                   term_last;
    logic                   done;
    logic [LANES*BUD_W-1:0] kept_cnt;
    logic [LANES-1:0]       dropped;

    hese_term_scheduler #(
        .LANES (LANES),
        .W     (W),
        .BUD_W (BUD_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_budget    (in_budget),
        .enc_input    (enc_input),
        .enc_power_on (enc_power_on),
        .enc_output   (enc_output),
        .enc_sign     (enc_sign),
        .term_valid   (term_valid),
        .term_mag     (term_mag),
        .term_sign    (term_sign),
        .term_weight  (term_weight),
        .term_last    (term_last),
        .done         (done),
        .kept_cnt     (kept_cnt),
        .dropped      (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder model: gated clock = clk & power_on, pair (older, newer).
    // Digit = newer - older; never reset.
    bit [LANES-1:0] enc_old;
    bit [LANES-1:0] enc_new;
    always @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (enc_power_on[i] === 1'b1) begin
                enc_new[i] <= enc_input[i];
                enc_old[i] <= enc_new[i];
            end
        end
    end
    assign enc_output = enc_old ^ enc_new;
    assign enc_sign   = enc_old & ~enc_new;

    typedef struct packed {
        logic [LANES-1:0] mag;
        logic [LANES-1:0] sign;
        logic [CNT_W-1:0] weight;
        logic             last;
    } slot_t;

    typedef struct packed {
        logic [LANES*BUD_W-1:0]  kept;
        logic [LANES-1:0]        dropped;
        logic [LANES-1:0][15:0]  value;
    } res_t;

    slot_t sb_slot[$];
    res_t  sb_res[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [LANES-1:0][15:0] obs_val;
    logic [LANES-1:0][15:0] last_val;

    // Expected digits: digit_k = b_{k-1} - b_k for k = W..0, first `bud`
    // nonzero digits kept per lane.
    task automatic push_expect(input logic [LANES*W-1:0] data, input logic [BUD_W-1:0] bud);
        slot_t      s;
        res_t       r;
        int         cnt [LANES];
        logic [W-1:0] wd;
        logic       bk;
        logic       bkm1;
        int         v;
        r = '0;
        for (int i = 0; i < LANES; i++) cnt[i] = 0;
        for (int k = W; k >= 0; k--) begin
            s = '0;
            s.weight = CNT_W'(k);
            s.last = (k == 0);
            for (int i = 0; i < LANES; i++) begin
                wd = data[i*W +: W];
                bk = (k < W) ? wd[k] : 1'b0;
                bkm1 = (k > 0) ? wd[k-1] : 1'b0;
                if (wd != '0 && (bk ^ bkm1)) begin
                    if (cnt[i] < int'(bud)) begin
                        s.mag[i] = 1'b1;
                        s.sign[i] = bk;
                        cnt[i]++;
                        v = bk ? -(1 << k) : (1 << k);
                        r.value[i] = r.value[i] + 16'(v);
                    end else begin
                        r.dropped[i] = 1'b1;
                    end
                end
            end
            sb_slot.push_back(s);
        end
        for (int i = 0; i < LANES; i++) r.kept[i*BUD_W +: BUD_W] = BUD_W'(cnt[i]);
        sb_res.push_back(r);
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        slot_t s;
        res_t  r;
        int    v;
        #1;
        if (reset === 1'b1) begin
            sb_slot.delete();
            sb_res.delete();
            obs_val = '0;
        end else begin
            if (term_valid === 1'b1) begin
                if (sb_slot.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_term: weight=%0d with no slot expected", term_weight);
                end else begin
                    s = sb_slot.pop_front();
                    total_cnt++;
                    if (term_mag !== s.mag)
                        $display("FAIL term_mag k=%0d: got %b required %b", s.weight, term_mag, s.mag);
                    else pass_cnt++;
                    total_cnt++;
                    if (term_sign !== s.sign)
                        $display("FAIL term_sign k=%0d: got %b required %b", s.weight, term_sign, s.sign);
                    else pass_cnt++;
                    total_cnt++;
                    if (term_weight !== s.weight)
                        $display("FAIL term_weight: got %0d required %0d", term_weight, s.weight);
                    else pass_cnt++;
                    total_cnt++;
                    if (term_last !== s.last)
                        $display("FAIL term_last k=%0d: got %b required %b", s.weight, term_last, s.last);
                    else pass_cnt++;
                    for (int i = 0; i < LANES; i++) begin
                        if (term_mag[i] === 1'b1) begin
                            v = term_sign[i] ? -(1 << term_weight) : (1 << term_weight);
                            obs_val[i] = obs_val[i] + 16'(v);
                        end
                    end
                end
            end
            if (done === 1'b1) begin
                if (sb_res.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_done: done=1 with no op outstanding");
                end else begin
                    r = sb_res.pop_front();
                    total_cnt++;
                    if (kept_cnt !== r.kept)
                        $display("FAIL kept_cnt: got %h required %h", kept_cnt, r.kept);
                    else pass_cnt++;
                    total_cnt++;
                    if (dropped !== r.dropped)
                        $display("FAIL dropped: got %b required %b", dropped, r.dropped);
                    else pass_cnt++;
                    total_cnt++;
                    if (obs_val !== r.value)
                        $display("FAIL quant_value: got %h required %h", obs_val, r.value);
                    else pass_cnt++;
                end
                last_val = obs_val;
                obs_val = '0;
            end
        end
    end

    // One full op; entered and left at a mid-cycle sample point in IDLE.
    task automatic run_op(input logic [LANES*W-1:0] data, input logic [BUD_W-1:0] bud,
                          input bit hold);
        logic [LANES-1:0] nz;
        logic [LANES-1:0] exp_pwr;
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            total_cnt++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
            return;
        end
        for (int i = 0; i < LANES; i++) nz[i] = |data[i*W +: W];
        in_data = data;
        in_budget = bud;
        in_valid = 1'b1;
        push_expect(data, bud);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        for (int c = 0; c <= W + 4; c++) begin
            @(negedge clk);
            #1;
            exp_pwr = (c <= W + 2) ? nz : '0;
            total_cnt++;
            if (enc_power_on !== exp_pwr)
                $display("FAIL power_on c=%0d: got %b required %b", c, enc_power_on, exp_pwr);
            else pass_cnt++;
            total_cnt++;
            if (in_ready !== (c == W + 4))
                $display("FAIL in_ready c=%0d: got %b required %b", c, in_ready, c == W + 4);
            else pass_cnt++;
            total_cnt++;
            if (done !== (c == W + 3))
                $display("FAIL done c=%0d: got %b required %b", c, done, c == W + 3);
            else pass_cnt++;
            total_cnt++;
            if (term_valid !== (c >= 2 && c <= W + 2))
                $display("FAIL term_valid c=%0d: got %b required %b", c, term_valid,
                         c >= 2 && c <= W + 2);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_budget = '0;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({in_ready, term_valid, done, term_last} !== 4'b1000)
            $display("FAIL reset_ctrl: got %b required 1000", {in_ready, term_valid, done, term_last});
        else pass_cnt++;
        total_cnt++;
        if ({enc_power_on, enc_input, term_mag, term_sign, dropped} !== '0)
            $display("FAIL reset_lanes: got %h required 0",
                     {enc_power_on, enc_input, term_mag, term_sign, dropped});
        else pass_cnt++;
        total_cnt++;
        if ({kept_cnt, term_weight} !== '0)
            $display("FAIL reset_counts: got %h required 0", {kept_cnt, term_weight});
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_basic();
        run_op({8'h3C, 8'hA5, 8'h01, 8'h07}, 4'd2, 1'b0);
        total_cnt++;
        if (last_val[0] !== 16'd7)
            $display("FAIL basic_value: got %0d required 7", last_val[0]);
        else pass_cnt++;
    endtask

    task automatic test_budget_one();
        run_op({8'h00, 8'h00, 8'h00, 8'h07}, 4'd1, 1'b0);
        total_cnt++;
        if (last_val[0] !== 16'd8)
            $display("FAIL budget_one_value: got %0d required 8", last_val[0]);
        else pass_cnt++;
    endtask

    task automatic test_alternating();
        run_op({8'hAA, 8'h33, 8'h0F, 8'h55}, 4'd8, 1'b0);
        total_cnt++;
        if (last_val[0] !== 16'd85)
            $display("FAIL alt_full_value: got %0d required 85", last_val[0]);
        else pass_cnt++;
        run_op({8'hAA, 8'h33, 8'h0F, 8'h55}, 4'd3, 1'b0);
        total_cnt++;
        if (last_val[0] !== 16'd96)
            $display("FAIL alt_bud3_value: got %0d required 96", last_val[0]);
        else pass_cnt++;
        run_op({8'hAA, 8'h33, 8'h0F, 8'h55}, 4'd0, 1'b0);
        total_cnt++;
        if (last_val[0] !== 16'd0)
            $display("FAIL alt_bud0_value: got %0d required 0", last_val[0]);
        else pass_cnt++;
        run_op({8'hAA, 8'h33, 8'h0F, 8'h55}, 4'd15, 1'b0);
    endtask

    task automatic test_mixed_lanes();
        run_op({8'h80, 8'h80, 8'h00, 8'hFF}, 4'd9, 1'b0);
        total_cnt++;
        if (last_val !== {16'd128, 16'd128, 16'd0, 16'd255})
            $display("FAIL mixed_values: got %h required %h", last_val,
                     {16'd128, 16'd128, 16'd0, 16'd255});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        in_data = {8'h11, 8'hC3, 8'h7E, 8'h07};
        in_budget = 4'd2;
        in_valid = 1'b1;
        push_expect(in_data, in_budget);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({term_valid, enc_power_on, enc_input, term_mag, done} !== '0)
            $display("FAIL midreset_outputs: got %h required 0",
                     {term_valid, enc_power_on, enc_input, term_mag, done});
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1)
            $display("FAIL midreset_ready: got %b required 1", in_ready);
        else pass_cnt++;
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c <= W + 4; c++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if ({done, term_valid, in_ready} !== 3'b001)
                $display("FAIL midreset_quiet c=%0d: got %b required 001", c,
                         {done, term_valid, in_ready});
            else pass_cnt++;
        end
        run_op({8'h3C, 8'hA5, 8'h01, 8'h07}, 4'd2, 1'b0);
        total_cnt++;
        if (last_val[0] !== 16'd7)
            $display("FAIL post_reset_value: got %0d required 7", last_val[0]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [LANES*W-1:0] d;
        for (int n = 0; n < 4; n++) begin
            d = {$urandom(), $urandom()};
            run_op(d, BUD_W'($urandom_range(0, 10)), n != 3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        obs_val = '0;
        last_val = '0;
        test_reset();
        test_basic();
        test_budget_one();
        test_alternating();
        test_mixed_lanes();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        total_cnt++;
        if (sb_slot.size() != 0 || sb_res.size() != 0)
            $display("FAIL scoreboard_drain: got %0d/%0d entries left required 0/0",
                     sb_slot.size(), sb_res.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
